// File: rtl/ber_test_ctrl.sv
// PRBS7 BER test sequencer: aligner reset/lock with timeout and retry, settle interval,
// then a counted measurement window with saturating frame and error totals.
module ber_test_ctrl #(
    parameter int unsigned RST_CYC       = 16,
    parameter int unsigned ALIGN_TIMEOUT = 4096,
    parameter int unsigned SETTLE_CYC    = 64,
    parameter int unsigned RETRY_MAX     = 8,
    parameter int unsigned ERR_W         = 7,
    parameter int unsigned TOT_W         = 48
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [TOT_W-1:0] window_len_i,
    input  logic             aligned_i,
    input  logic [ERR_W-1:0] err_cnt_in_i,
    output logic             align_rst_o,
    output logic [2:0]       state_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic [TOT_W-1:0] frames_cnt_o,
    output logic [TOT_W-1:0] err_total_o,
    output logic             err_sat_o,
    output logic [7:0]       relock_cnt_o,
    output logic [7:0]       retry_cnt_o
);

    localparam int unsigned TMR_M1  = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int unsigned TMR_MAX = (ALIGN_TIMEOUT > TMR_M1) ? ALIGN_TIMEOUT : TMR_M1;
    localparam int unsigned TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
    localparam int unsigned SUM_W   = TOT_W + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ALIGN_RST = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_SETTLE    = 3'd3,
        S_MEASURE   = 3'd4,
        S_DONE      = 3'd5,
        S_FAIL      = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [TOT_W-1:0] window_q, window_d;
    logic [TOT_W-1:0] frames_q, frames_d;
    logic [TOT_W-1:0] err_total_q, err_total_d;
    logic             err_sat_q, err_sat_d;
    logic [7:0]       relock_q, relock_d;
    logic [7:0]       retry_q, retry_d;
    logic             align_rst_q, align_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;

    logic             busy_c;
    logic             start_ok_c;
    logic             count_c;
    logic             win_hit_c;
    logic [TOT_W-1:0] frames_inc_c;
    logic [SUM_W-1:0] err_sum_c;
    logic [7:0]       retry_inc_c;

    assign busy_c       = (state_q == S_ALIGN_RST) || (state_q == S_WAIT_LOCK) ||
                          (state_q == S_SETTLE)    || (state_q == S_MEASURE);
    assign start_ok_c   = start_i && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                      (state_q == S_FAIL));
    assign count_c      = (state_q == S_MEASURE) && aligned_i;
    assign frames_inc_c = (&frames_q) ? frames_q : frames_q + TOT_W'(1);
    assign win_hit_c    = (window_q != '0) && (frames_inc_c == window_q);
    assign err_sum_c    = {1'b0, err_total_q} + SUM_W'(err_cnt_in_i);
    assign retry_inc_c  = retry_q + 8'd1;

    // State register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop overrides every other busy-state transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_i) state_d = S_ALIGN_RST;
            end
            S_ALIGN_RST: begin
                if (tmr_q == TMR_W'(RST_CYC - 1)) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (aligned_i) begin
                    state_d = S_SETTLE;
                end else if (tmr_q == TMR_W'(ALIGN_TIMEOUT - 1)) begin
                    state_d = (retry_inc_c == 8'(RETRY_MAX)) ? S_FAIL : S_ALIGN_RST;
                end
            end
            S_SETTLE: begin
                if (!aligned_i) begin
                    state_d = S_ALIGN_RST;
                end else if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
                    state_d = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (!aligned_i) begin
                    state_d = S_ALIGN_RST;
                end else if (win_hit_c) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (busy_c && stop_i) state_d = S_DONE;
    end

    // Output / datapath next values
    always_comb begin
        tmr_d       = tmr_q;
        window_d    = window_q;
        frames_d    = frames_q;
        err_total_d = err_total_q;
        err_sat_d   = err_sat_q;
        relock_d    = relock_q;
        retry_d     = retry_q;
        align_rst_d = (state_d == S_ALIGN_RST);
        busy_d      = (state_d inside {S_ALIGN_RST, S_WAIT_LOCK, S_SETTLE, S_MEASURE});
        done_d      = (state_d == S_DONE);
        fail_d      = (state_d == S_FAIL);

        // One shared timer: restarts on every state change
        if (state_d != state_q) begin
            tmr_d = '0;
        end else if (busy_c && (state_q != S_MEASURE)) begin
            tmr_d = tmr_q + TMR_W'(1);
        end

        if (start_ok_c) begin
            window_d    = window_len_i;
            frames_d    = '0;
            err_total_d = '0;
            err_sat_d   = 1'b0;
            relock_d    = '0;
            retry_d     = '0;
        end

        if (count_c) begin
            frames_d = frames_inc_c;
            if (err_sum_c[TOT_W] || (&err_sum_c[TOT_W-1:0])) begin
                err_total_d = '1;
                err_sat_d   = 1'b1;
            end else begin
                err_total_d = err_sum_c[TOT_W-1:0];
            end
        end

        if (((state_q == S_SETTLE) || (state_q == S_MEASURE)) &&
            (state_d == S_ALIGN_RST) && (relock_q != 8'hFF)) begin
            relock_d = relock_q + 8'd1;
        end

        if ((state_q == S_WAIT_LOCK) &&
            ((state_d == S_ALIGN_RST) || (state_d == S_FAIL))) begin
            retry_d = retry_inc_c;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tmr_q       <= '0;
            window_q    <= '0;
            frames_q    <= '0;
            err_total_q <= '0;
            err_sat_q   <= 1'b0;
            relock_q    <= '0;
            retry_q     <= '0;
            align_rst_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            tmr_q       <= tmr_d;
            window_q    <= window_d;
            frames_q    <= frames_d;
            err_total_q <= err_total_d;
            err_sat_q   <= err_sat_d;
            relock_q    <= relock_d;
            retry_q     <= retry_d;
            align_rst_q <= align_rst_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    assign state_o      = state_q;
    assign align_rst_o  = align_rst_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign fail_o       = fail_q;
    assign frames_cnt_o = frames_q;
    assign err_total_o  = err_total_q;
    assign err_sat_o    = err_sat_q;
    assign relock_cnt_o = relock_q;
    assign retry_cnt_o  = retry_q;

endmodule

// File: tb/tb_ber_test_ctrl.sv
// Bench for ber_test_ctrl: drives planned lock/settle/measure timelines with random
// error and alignment traffic, and tracks expected totals with plain arithmetic.
module tb_ber_test_ctrl;

    localparam int unsigned TOT_W = 48;
    localparam int unsigned ERR_W = 7;
    localparam logic [TOT_W-1:0] ALL1 = '1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             aligned = 1'b0;
    logic [TOT_W-1:0] window_len = '0;
    logic [ERR_W-1:0] err_in = '0;

    logic             align_rst;
    logic [2:0]       state;
    logic             busy, done, fail, err_sat;
    logic [TOT_W-1:0] frames_cnt, err_total;
    logic [7:0]       relock_cnt, retry_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    logic [TOT_W-1:0] exp_frames, exp_err, exp_win;
    logic             exp_sat;
    int               exp_relock, exp_retry;
    int               err_mode, w_idx;

    ber_test_ctrl dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .start_i      (start),
        .stop_i       (stop),
        .window_len_i (window_len),
        .aligned_i    (aligned),
        .err_cnt_in_i (err_in),
        .align_rst_o  (align_rst),
        .state_o      (state),
        .busy_o       (busy),
        .done_o       (done),
        .fail_o       (fail),
        .frames_cnt_o (frames_cnt),
        .err_total_o  (err_total),
        .err_sat_o    (err_sat),
        .relock_cnt_o (relock_cnt),
        .retry_cnt_o  (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [TOT_W-1:0] sat_add(input logic [TOT_W-1:0] a,
                                                 input logic [ERR_W-1:0] b);
        logic [63:0] s;
        s = 64'(a) + 64'(b);
        return (s > 64'(ALL1)) ? ALL1 : s[TOT_W-1:0];
    endfunction

    function automatic logic [ERR_W-1:0] gen_err(input int idx);
        if (err_mode == 1) return (idx % 10 == 9) ? ERR_W'(1) : ERR_W'(0);
        if (err_mode == 2) return ERR_W'(127);
        return ($urandom_range(0, 3) == 0) ? ERR_W'($urandom_range(1, 127)) : ERR_W'(0);
    endfunction

    task automatic check_all(input string tag, input int st);
        check_eq({tag, ".state"},  64'(state), 64'(st));
        check_eq({tag, ".busy"},   64'(busy), 64'(st >= 1 && st <= 4));
        check_eq({tag, ".done"},   64'(done), 64'(st == 5));
        check_eq({tag, ".fail"},   64'(fail), 64'(st == 6));
        check_eq({tag, ".arst"},   64'(align_rst), 64'(st == 1));
        check_eq({tag, ".frames"}, 64'(frames_cnt), 64'(exp_frames));
        check_eq({tag, ".err"},    64'(err_total), 64'(exp_err));
        check_eq({tag, ".sat"},    64'(err_sat), 64'(exp_sat));
        check_eq({tag, ".relock"}, 64'(relock_cnt), 64'(exp_relock));
        check_eq({tag, ".retry"},  64'(retry_cnt), 64'(exp_retry));
    endtask

    task automatic count_word(input logic [ERR_W-1:0] e);
        if (exp_frames != ALL1) exp_frames = exp_frames + 1;
        exp_err = sat_add(exp_err, e);
        exp_sat = exp_sat | (exp_err == ALL1);
    endtask

    task automatic relock_inc();
        if (exp_relock < 255) exp_relock++;
    endtask

    task automatic do_start(input logic [TOT_W-1:0] win, input logic with_stop);
        window_len = win;
        start = 1'b1;
        stop  = with_stop;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        exp_frames = '0; exp_err = '0; exp_sat = 1'b0;
        exp_relock = 0;  exp_retry = 0;
        exp_win = win;   w_idx = 0;
        check_all("start", 1);
        window_len = {$urandom, $urandom};
    endtask

    task automatic lock(input int k);
        for (int i = 0; i < 16; i++) begin
            check_eq("arst_hold", 64'(align_rst), 64'd1);
            aligned = 1'($urandom_range(0, 1));
            err_in  = ERR_W'($urandom);
            tick();
        end
        aligned = 1'b0;
        check_all("wait_lock", 2);
        repeat (k) tick();
        aligned = 1'b1;
        tick();
        check_all("settle_in", 3);
    endtask

    task automatic fail_attempt();
        for (int i = 0; i < 16; i++) begin
            check_eq("arst_hold_f", 64'(align_rst), 64'd1);
            tick();
        end
        aligned = 1'b0;
        check_all("wait_lock_f", 2);
        repeat (4095) begin
            err_in = ERR_W'($urandom);
            tick();
        end
        check_eq("wait_lock_last", 64'(state), 64'd2);
        tick();
        exp_retry++;
        check_all("timeout", (exp_retry == 8) ? 6 : 1);
    endtask

    task automatic settle();
        aligned = 1'b1;
        repeat (63) begin
            err_in = ERR_W'($urandom);
            tick();
        end
        check_eq("settle_last", 64'(state), 64'd3);
        tick();
        check_all("measure_in", 4);
    endtask

    task automatic settle_drop(input int j);
        aligned = 1'b1;
        repeat (j) tick();
        check_eq("settle_pre_drop", 64'(state), 64'd3);
        aligned = 1'b0;
        tick();
        relock_inc();
        check_all("settle_drop", 1);
    endtask

    task automatic measure_drop();
        aligned = 1'b0;
        err_in  = ERR_W'($urandom_range(1, 127));
        tick();
        relock_inc();
        check_all("meas_drop", 1);
    endtask

    task automatic measure_words(input int n);
        logic hit;
        for (int i = 0; i < n; i++) begin
            aligned = 1'b1;
            err_in  = gen_err(w_idx);
            w_idx++;
            tick();
            count_word(err_in);
            hit = (exp_win != '0) && (exp_frames == exp_win);
            check_eq("meas_frames", 64'(frames_cnt), 64'(exp_frames));
            check_eq("meas_err", 64'(err_total), 64'(exp_err));
            check_eq("meas_sat", 64'(err_sat), 64'(exp_sat));
            check_eq("meas_state", 64'(state), hit ? 64'd5 : 64'd4);
            if (hit) break;
        end
    endtask

    task automatic stop_word(input logic with_start);
        aligned = 1'b1;
        err_in  = gen_err(w_idx);
        w_idx++;
        start = with_start;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        count_word(err_in);
        check_all("stop", 5);
    endtask

    initial begin
        exp_frames = '0; exp_err = '0; exp_sat = 1'b0; exp_win = '0;
        exp_relock = 0;  exp_retry = 0; err_mode = 0; w_idx = 0;
        tick();
        tick();
        check_all("reset", 0);
        reset_n = 1'b1;
        tick();

        // 1000-word window, lock 10 cycles into WAIT_LOCK, one error per 10 words
        err_mode = 1;
        do_start(48'd1000, 1'b0);
        lock(10);
        settle();
        measure_words(1000);
        check_all("win1000", 5);
        check_eq("win1000_err_const", 64'(err_total), 64'd100);

        // single-cycle lock loss at word 500
        do_start(48'd1000, 1'b0);
        lock($urandom_range(0, 30));
        settle();
        measure_words(500);
        measure_drop();
        lock($urandom_range(0, 30));
        settle();
        measure_words(500);
        check_all("relock_run", 5);
        check_eq("relock_frames_const", 64'(frames_cnt), 64'd1000);

        // aligner never locks: eight timed-out attempts then FAIL
        err_mode = 0;
        do_start(48'($urandom_range(1, 100)), 1'b0);
        repeat (8) fail_attempt();
        check_eq("fail_retry_const", 64'(retry_cnt), 64'd8);

        // start+stop together from FAIL starts a run; start while busy is ignored
        do_start(48'd50, 1'b1);
        lock(3);
        settle();
        measure_words(10);
        start = 1'b1;
        measure_words(1);
        start = 1'b0;
        stop_word(1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_all("stop_in_done", 5);

        // stop during ALIGN_RST
        do_start(48'd20, 1'b0);
        repeat (5) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_all("stop_arst", 5);

        // window of one word
        do_start(48'd1, 1'b0);
        lock(0);
        settle();
        measure_words(5);
        check_all("win1", 5);

        // randomized runs with settle/measure drops and an occasional timeout
        for (int r = 0; r < 4; r++) begin
            int unsigned w, p;
            w = $urandom_range(2, 300);
            p = $urandom_range(1, w - 1);
            do_start(48'(w), 1'b0);
            if (r == 0) fail_attempt();
            lock($urandom_range(0, 40));
            if (r[0]) begin
                settle_drop($urandom_range(0, 63));
                lock($urandom_range(0, 40));
            end
            settle();
            measure_words(int'(p));
            measure_drop();
            lock($urandom_range(0, 40));
            settle();
            measure_words(int'(w - p));
            check_all("rand_done", 5);
        end

        // error total saturation with window_len=0, then stop
        err_mode = 2;
        do_start(48'd0, 1'b0);
        lock(2);
        settle();
        measure_words(20);
        force dut.err_total_q = ALL1 - 48'd300;
        aligned = 1'b1;
        err_in  = ERR_W'(127);
        tick();
        release dut.err_total_q;
        exp_frames = exp_frames + 1;
        repeat (5) tick();
        exp_frames = exp_frames + 5;
        exp_err = ALL1;
        exp_sat = 1'b1;
        check_all("sat", 4);
        measure_words(3);
        stop_word(1'b0);

        // asynchronous reset in the middle of MEASURE
        err_mode = 0;
        do_start(48'd0, 1'b0);
        lock(5);
        settle();
        measure_words(30);
        #2 reset_n = 1'b0;
        #1;
        exp_frames = '0; exp_err = '0; exp_sat = 1'b0;
        exp_relock = 0;  exp_retry = 0;
        check_all("async_rst", 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_all("post_rst", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
